line_window_buffer: RTL and testbench
=====================================

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter LINE_LEN, default 512, pixels per image line; any value >= KERNEL_W, power of two not required.
REQ-003 SHALL have parameter KERNEL_W, default 3, horizontal window taps; legal range 1..LINE_LEN.
REQ-004 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_data  input  DATA_W  write pixel.
REQ-007 SHALL have port i_data_valid  input  1  write request.
REQ-008 SHALL have port i_rd_data  input  1  advance window by one position.
REQ-009 SHALL have port o_data  output  KERNEL_W*DATA_W  window; tap 0 (oldest pixel) in the MS slice.
REQ-010 SHALL have port o_data_valid  output  1  window holds KERNEL_W stored pixels.
REQ-011 SHALL have port o_full  output  1  occupancy == LINE_LEN.
REQ-012 SHALL have port o_empty  output  1  occupancy == 0.
REQ-013 SHALL have port o_line_done  output  1  one-cycle pulse after last window of a line consumed.
REQ-014 SHALL have port o_overflow  output  1  sticky: write attempted while full.

Function
REQ-015 SHALL store pixels in a LINE_LEN-deep array; wr_ptr, rd_ptr wrap LINE_LEN-1 -> 0.
REQ-016 Write accepted when i_data_valid && !o_full; pixel at wr_ptr, wr_ptr+1 (mod LINE_LEN).
REQ-017 Write while full SHALL be dropped and set o_overflow until reset; array and pointers unchanged.
REQ-018 o_data tap k SHALL be array[(rd_ptr+k) mod LINE_LEN], combinational, zero latency.
REQ-019 o_data_valid SHALL equal (count >= KERNEL_W); o_data contents undefined when low.
REQ-020 Read accepted when i_rd_data && o_data_valid; i_rd_data with o_data_valid low SHALL be ignored.
REQ-021 Column counter col SHALL count accepted reads 0..LINE_LEN-KERNEL_W.
REQ-022 Accepted read with col < LINE_LEN-KERNEL_W: rd_ptr+1, count-1, col+1.
REQ-023 Accepted read with col == LINE_LEN-KERNEL_W: rd_ptr+KERNEL_W (mod LINE_LEN), count-KERNEL_W, col=0, o_line_done high next cycle only.
REQ-024 Simultaneous accepted write and read SHALL update count by +1 minus released amount in one cycle.
REQ-025 Write accepted in cycle N SHALL be visible in o_data/o_data_valid from cycle N+1.
REQ-026 Read while full with simultaneous write: write dropped (full evaluated before the read), overflow set.
REQ-027 count width SHALL be $clog2(LINE_LEN+1); no arithmetic overflow/underflow reachable.

Reset
REQ-028 i_rst_n low SHALL asynchronously clear wr_ptr, rd_ptr, col, count, o_line_done, o_overflow.
REQ-029 During reset: o_empty=1, o_full=0, o_data_valid=0, o_line_done=0, o_overflow=0.
REQ-030 Array contents SHALL NOT be reset; reset mid-line discards the partial line.
REQ-031 Reset deassertion SHALL be synchronised externally; the block assumes it is clean.

Structure
REQ-032 Package line_buf_pkg SHALL hold default DATA_W, LINE_LEN, KERNEL_W and a pointer-width helper.
REQ-033 Sub-module mod_counter (modulo-N wrapping counter with variable increment) SHALL implement wr_ptr and rd_ptr.
REQ-034 Array SHALL be inferable as distributed RAM with KERNEL_W asynchronous read taps.

Verification (LINE_LEN=8, KERNEL_W=3, DATA_W=8 unless stated)
REQ-035 Write 0x10..0x12 -> o_data_valid rises the cycle after third write, o_data=0x101112.
REQ-036 Write 8 pixels 0x00..0x07, 9th write 0xFF -> o_full=1, o_overflow=1, o_data=0x000102 unchanged.
REQ-037 Full line, 6 reads -> windows 000102..050607, o_line_done pulse after 6th read, count=0, o_empty=1.
REQ-038 Continuous write+read each cycle across 3 lines -> wr/rd pointers wrap, no drop, windows contiguous per line, 3 line_done pulses.
REQ-039 i_rd_data held high with count=2 -> no pointer movement, count stays 2.
REQ-040 Assert i_rst_n low asynchronously after 5 writes -> outputs reach reset values before next clock edge; subsequent write 0xAA lands at address 0.

Source files
------------

// File: rtl/line_buf_pkg.sv
// Shared defaults and sizing helpers for the line window buffer.
package line_buf_pkg;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefLineLen = 512;
  localparam int unsigned DefKernelW = 3;

  // Address width for an n-entry array; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_window_buffer_if.sv
// Pixel write / window read bus of the line window buffer.
interface line_window_buffer_if
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned KERNEL_W = DefKernelW
);

  logic [DATA_W-1:0]          i_data;
  logic                       i_data_valid;
  logic                       i_rd_data;
  logic [KERNEL_W*DATA_W-1:0] o_data;
  logic                       o_data_valid;
  logic                       o_full;
  logic                       o_empty;
  logic                       o_line_done;
  logic                       o_overflow;

  modport master (
    output i_data, i_data_valid, i_rd_data,
    input  o_data, o_data_valid, o_full, o_empty, o_line_done, o_overflow
  );

  modport slave (
    input  i_data, i_data_valid, i_rd_data,
    output o_data, o_data_valid, o_full, o_empty, o_line_done, o_overflow
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-N wrapping counter with a variable increment (increment must not exceed N).
module mod_counter #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = 3,
  parameter int unsigned IncW = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [IncW-1:0] i_inc,
  output logic [W-1:0]    o_cnt
);

  localparam int unsigned SumW = ((W > IncW) ? W : IncW) + 1;

  logic [W-1:0]    cnt_q, cnt_d;
  logic [SumW-1:0] sum;

  // cnt < N and inc <= N, so one conditional subtract is enough to wrap.
  always_comb begin
    sum = SumW'(cnt_q) + SumW'(i_inc);
    if (sum >= SumW'(N)) begin
      sum = sum - SumW'(N);
    end
    cnt_d = W'(sum);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/line_window_buffer.sv
// One-line pixel store presenting a KERNEL_W-wide sliding window; tap 0 (oldest) in the MS slice.
module line_window_buffer
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned LINE_LEN = DefLineLen,
  parameter int unsigned KERNEL_W = DefKernelW
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  line_window_buffer_if.slave  bus
);

  localparam int unsigned PtrW    = ptr_w(LINE_LEN);
  localparam int unsigned CntW    = $clog2(LINE_LEN + 1);
  localparam int unsigned LastCol = LINE_LEN - KERNEL_W;
  localparam int unsigned ColW    = ptr_w(LastCol + 1);
  localparam int unsigned IdxW    = PtrW + 1;

  logic [DATA_W-1:0] mem [LINE_LEN];

  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count_q, count_d, rel;
  logic [ColW-1:0] col_q, col_d;
  logic            line_done_q, overflow_q;
  logic            full, wr_en, rd_en, last_col;

  assign full     = (count_q == CntW'(LINE_LEN));
  assign wr_en    = bus.i_data_valid && !full;
  assign rd_en    = bus.i_rd_data && bus.o_data_valid;
  assign last_col = (col_q == ColW'(LastCol));
  // The final window of a line releases all of its taps at once.
  assign rel      = last_col ? CntW'(KERNEL_W) : CntW'(1);

  mod_counter #(
    .N    (LINE_LEN),
    .W    (PtrW),
    .IncW (1)
  ) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (wr_en),
    .i_inc   (1'b1),
    .o_cnt   (wr_ptr)
  );

  mod_counter #(
    .N    (LINE_LEN),
    .W    (PtrW),
    .IncW (CntW)
  ) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (rd_en),
    .i_inc   (rel),
    .o_cnt   (rd_ptr)
  );

  always_comb begin
    count_d = count_q + CntW'(wr_en) - (rd_en ? rel : '0);
    col_d   = col_q;
    if (rd_en) begin
      col_d = last_col ? '0 : col_q + ColW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q     <= '0;
      col_q       <= '0;
      line_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      col_q       <= col_d;
      line_done_q <= rd_en && last_col;
      overflow_q  <= overflow_q || (bus.i_data_valid && full);
    end
  end

  // Storage is deliberately unreset so it maps onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.i_data;
    end
  end

  for (genvar k = 0; k < KERNEL_W; k++) begin : g_tap
    logic [IdxW-1:0] idx_sum;
    always_comb begin
      idx_sum = {1'b0, rd_ptr} + IdxW'(k);
      if (idx_sum >= IdxW'(LINE_LEN)) begin
        idx_sum = idx_sum - IdxW'(LINE_LEN);
      end
    end
    assign bus.o_data[(KERNEL_W-1-k)*DATA_W +: DATA_W] = mem[idx_sum[PtrW-1:0]];
  end

  assign bus.o_data_valid = (count_q >= CntW'(KERNEL_W));
  assign bus.o_empty      = (count_q == '0);
  assign bus.o_full       = full;
  assign bus.o_line_done  = line_done_q;
  assign bus.o_overflow   = overflow_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench: vector table, directed corner sequences and a queue-based random model.
module tb_line_window_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned LL = 8;
  localparam int unsigned KW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  line_window_buffer_if #(.DATA_W(DW), .KERNEL_W(KW)) bus ();

  line_window_buffer #(
    .DATA_W   (DW),
    .LINE_LEN (LL),
    .KERNEL_W (KW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: the stored line as a FIFO of pixels plus column position.
  logic [DW-1:0] mq[$];
  int col  = 0;
  bit movf = 1'b0;
  bit mld  = 1'b0;

  typedef struct {
    bit          dv;
    logic [7:0]  d;
    bit          rd;
    bit          v;
    logic [23:0] data;
    bit          full;
    bit          empty;
    bit          ld;
    bit          ovf;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mwin();
    logic [23:0] w = '0;
    for (int k = 0; k < KW; k++) w = (w << DW) | 24'(mq[k]);
    return w;
  endfunction

  task automatic model_clear();
    mq.delete();
    col  = 0;
    movf = 1'b0;
    mld  = 1'b0;
  endtask

  task automatic cycle(input bit dv, input logic [7:0] d, input bit rd);
    bit full;
    bit acc_rd;
    bus.i_data_valid = dv;
    bus.i_data       = d;
    bus.i_rd_data    = rd;
    full   = (mq.size() == LL);
    acc_rd = rd && (mq.size() >= KW);
    @(posedge clk);
    #1;
    mld = acc_rd && (col == int'(LL - KW));
    if (dv && full) movf = 1'b1;
    if (acc_rd) begin
      if (col == int'(LL - KW)) begin
        repeat (KW) void'(mq.pop_front());
        col = 0;
      end else begin
        void'(mq.pop_front());
        col++;
      end
    end
    if (dv && !full) mq.push_back(d);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 64'(bus.o_data_valid), 64'(mq.size() >= KW));
    check({tag, "_full"},  64'(bus.o_full),       64'(mq.size() == LL));
    check({tag, "_empty"}, 64'(bus.o_empty),      64'(mq.size() == 0));
    check({tag, "_ld"},    64'(bus.o_line_done),  64'(mld));
    check({tag, "_ovf"},   64'(bus.o_overflow),   64'(movf));
    if (mq.size() >= KW) check({tag, "_data"}, 64'(bus.o_data), 64'(mwin()));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 64'(bus.o_empty),      64'd1);
    check({tag, "_full"},  64'(bus.o_full),       64'd0);
    check({tag, "_valid"}, 64'(bus.o_data_valid), 64'd0);
    check({tag, "_ld"},    64'(bus.o_line_done),  64'd0);
    check({tag, "_ovf"},   64'(bus.o_overflow),   64'd0);
  endtask

  task automatic do_reset();
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;
    bus.i_rd_data    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    int ld_seen;
    int ld_exp;
    int rdp;
    logic [7:0] px;

    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{dv: 1'b1, d: 8'(i), rd: 1'b0, v: (i >= 2), data: 24'h000102,
                 full: (i == 7), empty: 1'b0, ld: 1'b0, ovf: 1'b0};
    end
    tbl[8] = '{dv: 1'b1, d: 8'hFF, rd: 1'b0, v: 1'b1, data: 24'h000102,
               full: 1'b1, empty: 1'b0, ld: 1'b0, ovf: 1'b1};
    for (int k = 1; k <= 5; k++) begin
      tbl[8+k] = '{dv: 1'b0, d: 8'h00, rd: 1'b1, v: 1'b1,
                   data: {8'(k), 8'(k + 1), 8'(k + 2)},
                   full: 1'b0, empty: 1'b0, ld: 1'b0, ovf: 1'b1};
    end
    tbl[14] = '{dv: 1'b0, d: 8'h00, rd: 1'b1, v: 1'b0, data: 24'h0,
                full: 1'b0, empty: 1'b1, ld: 1'b1, ovf: 1'b1};
    tbl[15] = '{dv: 1'b0, d: 8'h00, rd: 1'b0, v: 1'b0, data: 24'h0,
                full: 1'b0, empty: 1'b1, ld: 1'b0, ovf: 1'b1};

    // First window appears the cycle after the third write.
    do_reset();
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    check("first_valid_early", 64'(bus.o_data_valid), 64'd0);
    cycle(1'b1, 8'h12, 1'b0);
    check("first_valid", 64'(bus.o_data_valid), 64'd1);
    check("first_data", 64'(bus.o_data), 64'h101112);

    // Fill, overflow, then consume a whole line.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].dv, tbl[i].d, tbl[i].rd);
      check($sformatf("tbl%0d_valid", i), 64'(bus.o_data_valid), 64'(tbl[i].v));
      check($sformatf("tbl%0d_full", i),  64'(bus.o_full),       64'(tbl[i].full));
      check($sformatf("tbl%0d_empty", i), 64'(bus.o_empty),      64'(tbl[i].empty));
      check($sformatf("tbl%0d_ld", i),    64'(bus.o_line_done),  64'(tbl[i].ld));
      check($sformatf("tbl%0d_ovf", i),   64'(bus.o_overflow),   64'(tbl[i].ovf));
      if (tbl[i].v) check($sformatf("tbl%0d_data", i), 64'(bus.o_data), 64'(tbl[i].data));
    end

    // Reads while the window is not yet valid must be ignored.
    do_reset();
    cycle(1'b1, 8'h20, 1'b0);
    cycle(1'b1, 8'h30, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("ign_valid", 64'(bus.o_data_valid), 64'd0);
    check("ign_empty", 64'(bus.o_empty), 64'd0);
    cycle(1'b1, 8'h40, 1'b0);
    check("ign_data", 64'(bus.o_data), 64'h203040);

    // Streaming write+read every cycle across several lines.
    do_reset();
    px = 8'h50;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, px, 1'b0);
      px++;
    end
    ld_seen = 0;
    ld_exp  = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, px, 1'b1);
      px++;
      check_model($sformatf("stream%0d", i));
      if (bus.o_line_done) ld_seen++;
      if (mld) ld_exp++;
    end
    check("stream_ld_count", 64'(ld_seen), 64'(ld_exp));
    check("stream_ld_ge3", 64'(ld_seen >= 3), 64'd1);

    // Asynchronous reset mid-line takes effect before the next edge.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    bus.i_data_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0);
    cycle(1'b1, 8'hCC, 1'b0);
    check("async_after_data", 64'(bus.o_data), 64'hAABBCC);

    // Randomised traffic, alternating read-light and read-heavy phases.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rdp = ((i / 100) % 2 == 0) ? 25 : 80;
      cycle(($urandom_range(0, 99) < 65), 8'($urandom), ($urandom_range(0, 99) < rdp));
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
